rst_sequencer: RTL and testbench

//  Consumes the PLL lock and Wishbone clock from clkgen; releases the system's synchronous resets in order:

---
 rtl/rst_seq_pkg.sv | 31 +++
 rtl/rst_sequencer_sync2.sv | 22 ++
 rtl/rst_sequencer.sv | 115 +++++++++++
 tb/tb_rst_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Reset sequencer shared types.
// State encoding is visible on seq_state_o.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    STABLE     = 3'd1,
    MEM_RST    = 3'd2,
    WAIT_CALIB = 3'd3,
    PERIPH_DLY = 3'd4,
    CPU_DLY    = 3'd5,
    RUN        = 3'd6,
    SW_HOLD    = 3'd7
  } seq_state_e;

  localparam int unsigned CNT_W_DEF = 17;
  localparam logic [3:0]  RETRY_MAX = 4'd15;

  function automatic logic mem_rst_of(input seq_state_e s);
    return s inside {WAIT_LOCK, STABLE, MEM_RST};
  endfunction

  function automatic logic periph_rst_of(input seq_state_e s);
    return !(s inside {CPU_DLY, RUN});
  endfunction

  function automatic logic cpu_rst_of(input seq_state_e s);
    return s != RUN;
  endfunction

endpackage

// File: rtl/rst_sequencer_sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
// Resets to 0 so a lost or unknown input reads as inactive.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// Ordered reset release: memory, peripherals, CPU.
// Calibration timeout retries, lock-loss and software reset.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned MEM_RST_CYCLES     = 16,
  parameter int unsigned CALIB_TIMEOUT      = 65535,
  parameter int unsigned PERIPH_DELAY       = 16,
  parameter int unsigned SW_HOLD_CYCLES     = 16,
  parameter int unsigned CNT_W              = CNT_W_DEF
) (
  input  logic       wb_clk_i,
  input  logic       rst_n_i,
  input  logic       pll_locked_i,
  input  logic       mem_calib_done_i,
  input  logic       sw_rst_req_i,
  output logic       mem_rst_o,
  output logic       periph_rst_o,
  output logic       cpu_rst_o,
  output logic [2:0] seq_state_o,
  output logic       calib_err_o,
  output logic [3:0] retry_cnt_o
);

  logic             lock_s;
  logic             calib_s;
  logic             timeout;
  seq_state_e       state;
  seq_state_e       nxt;
  logic [CNT_W-1:0] cnt;

  sync2 u_lock_sync (
    .clk   (wb_clk_i),
    .rst_n (rst_n_i),
    .d     (pll_locked_i),
    .q     (lock_s)
  );

  sync2 u_calib_sync (
    .clk   (wb_clk_i),
    .rst_n (rst_n_i),
    .d     (mem_calib_done_i),
    .q     (calib_s)
  );

  function automatic logic done(input logic [CNT_W-1:0] c,
                                input int unsigned n);
    return c == CNT_W'(n - 1);
  endfunction

  always_comb begin
    nxt     = state;
    timeout = 1'b0;
    if (!lock_s && state != WAIT_LOCK) begin
      nxt = WAIT_LOCK;
    end else if (sw_rst_req_i &&
                 state inside {PERIPH_DLY, CPU_DLY, RUN}) begin
      nxt = SW_HOLD;
    end else begin
      case (state)
        WAIT_LOCK:
          if (lock_s) nxt = STABLE;
        STABLE:
          if (done(cnt, LOCK_STABLE_CYCLES)) nxt = MEM_RST;
        MEM_RST:
          if (done(cnt, MEM_RST_CYCLES)) nxt = WAIT_CALIB;
        WAIT_CALIB:
          if (calib_s) begin
            nxt = PERIPH_DLY;
          end else if (done(cnt, CALIB_TIMEOUT)) begin
            nxt     = MEM_RST;
            timeout = 1'b1;
          end
        PERIPH_DLY:
          nxt = CPU_DLY;
        CPU_DLY:
          if (done(cnt, PERIPH_DELAY)) nxt = RUN;
        RUN:
          nxt = RUN;
        SW_HOLD:
          if (done(cnt, SW_HOLD_CYCLES)) nxt = PERIPH_DLY;
        default:
          nxt = WAIT_LOCK;
      endcase
    end
  end

  // Outputs decode nxt so they change on the same edge as state.
  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= WAIT_LOCK;
      cnt          <= '0;
      mem_rst_o    <= 1'b1;
      periph_rst_o <= 1'b1;
      cpu_rst_o    <= 1'b1;
      calib_err_o  <= 1'b0;
      retry_cnt_o  <= 4'd0;
    end else begin
      state        <= nxt;
      cnt          <= (nxt != state) ? '0 : cnt + 1'b1;
      mem_rst_o    <= mem_rst_of(nxt);
      periph_rst_o <= periph_rst_of(nxt);
      cpu_rst_o    <= cpu_rst_of(nxt);
      if (timeout) begin
        calib_err_o <= 1'b1;
        if (retry_cnt_o != RETRY_MAX)
          retry_cnt_o <= retry_cnt_o + 4'd1;
      end
    end
  end

  assign seq_state_o = state;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: vector table, corner sequences,
// and random stimulus against a deadline-based reference model.
module tb_rst_sequencer;

  logic       wb_clk = 1'b0;
  logic       rst_n;
  logic       lock;
  logic       calib;
  logic       sw;
  logic       mem_rst;
  logic       periph_rst;
  logic       cpu_rst;
  logic [2:0] st;
  logic       err;
  logic [3:0] retry;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  rst_sequencer #(
    .LOCK_STABLE_CYCLES (8),
    .MEM_RST_CYCLES     (4),
    .CALIB_TIMEOUT      (20),
    .PERIPH_DELAY       (4),
    .SW_HOLD_CYCLES     (6),
    .CNT_W              (17)
  ) dut (
    .wb_clk_i         (wb_clk),
    .rst_n_i          (rst_n),
    .pll_locked_i     (lock),
    .mem_calib_done_i (calib),
    .sw_rst_req_i     (sw),
    .mem_rst_o        (mem_rst),
    .periph_rst_o     (periph_rst),
    .cpu_rst_o        (cpu_rst),
    .seq_state_o      (st),
    .calib_err_o      (err),
    .retry_cnt_o      (retry)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct packed {
    logic       lock;
    logic       calib;
    logic       sw;
    logic [7:0] n;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [10:0] pack(input int s, input bit m,
    input bit p, input bit c, input bit e, input int r);
    logic [2:0] s3;
    logic [3:0] r4;
    s3 = 3'(s);
    r4 = 4'(r);
    return {s3, m, p, c, e, r4};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {st, mem_rst, periph_rst, cpu_rst, err, retry};
  endfunction

  task automatic add(input bit l, input bit c, input bit s,
    input int n, input int stv, input bit m, input bit p,
    input bit cp, input bit e, input int r);
    vec_t v;
    v.lock  = l;
    v.calib = c;
    v.sw    = s;
    v.n     = 8'(n);
    v.exp   = pack(stv, m, p, cp, e, r);
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [10:0] act,
                       input logic [10:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got st=%0d rst=%b%b%b err=%b rty=%0d, want st=%0d rst=%b%b%b err=%b rty=%0d",
        nm, act[10:8], act[7], act[6], act[5], act[4], act[3:0],
        exp[10:8], exp[7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  // Reference model: phases with absolute deadlines, sync as history.
  localparam int P_WL = 0, P_ST = 1, P_MR = 2, P_WC = 3;
  localparam int P_PD = 4, P_CD = 5, P_RUN = 6, P_SW = 7;
  int dur[8] = '{0, 8, 4, 20, 1, 4, 0, 6};

  int m_cyc, m_ph, m_dl, m_err, m_retry;
  bit lq[$];
  bit cq[$];

  task automatic model_reset();
    m_cyc = 0; m_ph = P_WL; m_dl = 0; m_err = 0; m_retry = 0;
    lq.delete();
    cq.delete();
  endtask

  task automatic go(input int p);
    m_ph = p;
    m_dl = m_cyc + dur[p];
  endtask

  task automatic model_edge(input bit pl, input bit pc, input bit ps);
    bit lk, cl, tmo;
    m_cyc++;
    lk = (lq.size() >= 2) ? lq[lq.size()-2] : 1'b0;
    cl = (cq.size() >= 2) ? cq[cq.size()-2] : 1'b0;
    lq.push_back(pl);
    cq.push_back(pc);
    tmo = (m_cyc == m_dl);
    if (!lk && m_ph != P_WL) go(P_WL);
    else if (ps && (m_ph == P_PD || m_ph == P_CD || m_ph == P_RUN))
      go(P_SW);
    else if (m_ph == P_WL) begin
      if (lk) go(P_ST);
    end else if (m_ph == P_WC) begin
      if (cl) go(P_PD);
      else if (tmo) begin
        go(P_MR);
        m_err = 1;
        if (m_retry < 15) m_retry++;
      end
    end else if (tmo && m_ph != P_RUN) begin
      case (m_ph)
        P_ST:    go(P_MR);
        P_MR:    go(P_WC);
        P_PD:    go(P_CD);
        P_CD:    go(P_RUN);
        default: go(P_PD);
      endcase
    end
  endtask

  function automatic logic [10:0] model_vec();
    return pack(m_ph, m_ph <= P_MR,
                !(m_ph == P_CD || m_ph == P_RUN),
                m_ph != P_RUN, m_err[0], m_retry);
  endfunction

  task automatic do_reset(input bit l, input bit c);
    rst_n = 1'b0;
    lock  = l;
    calib = c;
    sw    = 1'b0;
    repeat (2) @(negedge wb_clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; lock = 1'b1; calib = 1'b1; sw = 1'b0;
    repeat (3) @(negedge wb_clk);
    check("reset", dut_vec(), pack(P_WL, 1, 1, 1, 0, 0));
    rst_n = 1'b1;

    // l c s n st m p c e r
    add(1,1,0, 2, 0, 1,1,1,0,0);
    add(1,1,0, 1, 1, 1,1,1,0,0);
    add(1,1,0, 7, 1, 1,1,1,0,0);
    add(1,1,0, 1, 2, 1,1,1,0,0);
    add(1,1,0, 3, 2, 1,1,1,0,0);
    add(1,1,0, 1, 3, 0,1,1,0,0);
    add(1,1,0, 1, 4, 0,1,1,0,0);
    add(1,1,0, 1, 5, 0,0,1,0,0);
    add(1,1,0, 3, 5, 0,0,1,0,0);
    add(1,1,0, 1, 6, 0,0,0,0,0);
    add(1,1,1, 1, 7, 0,1,1,0,0);
    add(1,1,0, 5, 7, 0,1,1,0,0);
    add(1,1,0, 1, 4, 0,1,1,0,0);
    add(1,1,0, 1, 5, 0,0,1,0,0);
    add(1,1,0, 4, 6, 0,0,0,0,0);
    add(1,1,1, 2, 7, 0,1,1,0,0);
    add(1,1,0, 4, 7, 0,1,1,0,0);
    add(1,1,0, 1, 4, 0,1,1,0,0);
    add(1,1,0, 1, 5, 0,0,1,0,0);
    add(0,1,0, 2, 5, 0,0,1,0,0);
    add(0,1,1, 1, 0, 1,1,1,0,0);
    add(0,1,0, 5, 0, 1,1,1,0,0);
    add(1,0,0, 2, 0, 1,1,1,0,0);
    add(1,0,0, 1, 1, 1,1,1,0,0);
    add(1,0,0, 8, 2, 1,1,1,0,0);
    add(1,0,0, 4, 3, 0,1,1,0,0);
    add(1,0,0,19, 3, 0,1,1,0,0);
    add(1,0,0, 1, 2, 1,1,1,1,1);
    add(1,0,0, 4, 3, 0,1,1,1,1);
    add(1,1,0, 3, 4, 0,1,1,1,1);
    add(1,1,0, 1, 5, 0,0,1,1,1);

    for (int i = 0; i < tbl.size(); i++) begin
      lock  = tbl[i].lock;
      calib = tbl[i].calib;
      sw    = tbl[i].sw;
      repeat (int'(tbl[i].n)) @(posedge wb_clk);
      @(negedge wb_clk);
      check($sformatf("tbl%0d", i), dut_vec(), tbl[i].exp);
    end
    sw = 1'b0;

    // Asynchronous reset in CPU_DLY, then full rerun.
    #2 rst_n = 1'b0;
    #1 check("async_rst", dut_vec(), pack(P_WL, 1, 1, 1, 0, 0));
    @(negedge wb_clk);
    rst_n = 1'b1;
    repeat (2) @(posedge wb_clk);
    @(negedge wb_clk);
    check("rerun_wait", dut_vec(), pack(P_WL, 1, 1, 1, 0, 0));
    @(posedge wb_clk);
    @(negedge wb_clk);
    check("rerun_stable", dut_vec(), pack(P_ST, 1, 1, 1, 0, 0));

    // Retry counter saturation with calibration never done.
    do_reset(1'b1, 1'b0);
    repeat (371) @(posedge wb_clk);
    @(negedge wb_clk);
    check("retry15", dut_vec(), pack(P_MR, 1, 1, 1, 1, 15));
    repeat (48) @(posedge wb_clk);
    @(negedge wb_clk);
    check("retry_sat", dut_vec(), pack(P_MR, 1, 1, 1, 1, 15));
    repeat (4) @(posedge wb_clk);
    @(negedge wb_clk);
    check("still_retry", dut_vec(), pack(P_WC, 0, 1, 1, 1, 15));

    // Random stimulus against the reference model.
    do_reset(1'b1, 1'b0);
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      if (lock) begin
        if ($urandom_range(0, 399) == 0) lock = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        lock = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) calib = ~calib;
      sw = ($urandom_range(0, 15) == 0);
      @(posedge wb_clk);
      model_edge(lock, calib, sw);
      @(negedge wb_clk);
      check($sformatf("rand%0d", c), dut_vec(), model_vec());
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, miss_cnt);
    $finish;
  end

endmodule
